// File: rtl/cfs_tx_ctrl.sv
// TX controller of the Aligner: pops aligned packets from the TX FIFO and drives
// them on the MD TX interface, with slave error counting and stall detection.
module cfs_tx_ctrl #(
   parameter  int ALGN_DATA_WIDTH         = 32,
   parameter  int STATUS_CNT_TX_ERR_WIDTH = 8,
   parameter  int STALL_LIMIT_WIDTH       = 8,
   localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH / 8),
   localparam int ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH / 8) + 1,
   localparam int FIFO_DATA_WIDTH   = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH
) (
   input  logic                               md_tx_clk,
   input  logic                               preset_n,
   input  logic                               pop_valid,
   input  logic [FIFO_DATA_WIDTH-1:0]         pop_data,
   output logic                               pop_ready,
   output logic                               md_tx_valid,
   output logic [ALGN_DATA_WIDTH-1:0]         md_tx_data,
   output logic [ALGN_OFFSET_WIDTH-1:0]       md_tx_offset,
   output logic [ALGN_SIZE_WIDTH-1:0]         md_tx_size,
   input  logic                               md_tx_ready,
   input  logic                               md_tx_err,
   input  logic                               clr_cnt_tx_err,
   output logic [STATUS_CNT_TX_ERR_WIDTH-1:0] status_cnt_tx_err,
   input  logic [STALL_LIMIT_WIDTH-1:0]       stall_limit,
   output logic                               stall_irq
);

   localparam int CW = STATUS_CNT_TX_ERR_WIDTH;
   localparam int LW = STALL_LIMIT_WIDTH;
   localparam logic [CW-1:0] ERR_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0] ERR_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0] STALL_MAX = {LW{1'b1}};
   localparam logic [LW-1:0] STALL_ONE = {{(LW-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0] STALL_ZERO = {LW{1'b0}};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                         state_r;
   state_t                         state_s;
   logic                           pop_s;
   logic                           accept_s;
   logic                           stall_s;
   logic                           hit_s;
   logic [ALGN_DATA_WIDTH-1:0]     data_r;
   logic [ALGN_OFFSET_WIDTH-1:0]   offset_r;
   logic [ALGN_SIZE_WIDTH-1:0]     size_r;
   logic [CW-1:0]                  err_cnt_r;
   logic [LW-1:0]                  stall_cnt_r;
   logic                           fired_r;
   logic                           irq_r;

   function automatic logic [CW-1:0] err_sat_inc(input logic [CW-1:0] cnt);
      if (cnt == ERR_MAX) begin
         return cnt;
      end else begin
         return cnt + ERR_ONE;
      end
   endfunction

   // State register
   always_ff @(posedge md_tx_clk or negedge preset_n) begin
      if (!preset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (pop_valid) begin
               state_s = SEND;
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            if (md_tx_ready && !pop_valid) begin
               state_s = IDLE;
            end else begin
               state_s = SEND;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Per-state strobes: pop, accept and stall qualification
   always_comb begin
      pop_s    = 1'b0;
      accept_s = 1'b0;
      stall_s  = 1'b0;
      case (state_r)
         IDLE: begin
            pop_s = pop_valid;
         end
         SEND: begin
            pop_s    = pop_valid & md_tx_ready;
            accept_s = md_tx_ready;
            stall_s  = ~md_tx_ready;
         end
         default: begin
            pop_s    = 1'b0;
            accept_s = 1'b0;
            stall_s  = 1'b0;
         end
      endcase
   end

   // The stall pulse fires on the edge the counter reaches the limit, once per packet;
   // a counter already at or past a freshly lowered limit can never match again.
   assign hit_s = stall_s && (stall_limit != STALL_ZERO) && !fired_r &&
                  (stall_cnt_r != STALL_MAX) && ((stall_cnt_r + STALL_ONE) == stall_limit);

   // Output payload register, loaded on every pop
   always_ff @(posedge md_tx_clk or negedge preset_n) begin
      if (!preset_n) begin
         data_r   <= {ALGN_DATA_WIDTH{1'b0}};
         offset_r <= {ALGN_OFFSET_WIDTH{1'b0}};
         size_r   <= {ALGN_SIZE_WIDTH{1'b0}};
      end else if (pop_s) begin
         data_r   <= pop_data[ALGN_DATA_WIDTH-1:0];
         offset_r <= pop_data[ALGN_DATA_WIDTH +: ALGN_OFFSET_WIDTH];
         size_r   <= pop_data[ALGN_DATA_WIDTH+ALGN_OFFSET_WIDTH +: ALGN_SIZE_WIDTH];
      end
   end

   // Saturating slave-error counter; clear dominates a simultaneous error
   always_ff @(posedge md_tx_clk or negedge preset_n) begin
      if (!preset_n) begin
         err_cnt_r <= {CW{1'b0}};
      end else if (clr_cnt_tx_err) begin
         err_cnt_r <= {CW{1'b0}};
      end else if (accept_s && md_tx_err) begin
         err_cnt_r <= err_sat_inc(err_cnt_r);
      end
   end

   // Stall counter, once-per-packet flag and registered interrupt pulse
   always_ff @(posedge md_tx_clk or negedge preset_n) begin
      if (!preset_n) begin
         stall_cnt_r <= {LW{1'b0}};
         fired_r     <= 1'b0;
         irq_r       <= 1'b0;
      end else begin
         irq_r <= hit_s;
         if (stall_s) begin
            if (stall_cnt_r != STALL_MAX) begin
               stall_cnt_r <= stall_cnt_r + STALL_ONE;
            end
            if (hit_s) begin
               fired_r <= 1'b1;
            end
         end else begin
            stall_cnt_r <= {LW{1'b0}};
            fired_r     <= 1'b0;
         end
      end
   end

   assign pop_ready         = pop_s;
   assign md_tx_valid       = (state_r == SEND);
   assign md_tx_data        = data_r;
   assign md_tx_offset      = offset_r;
   assign md_tx_size        = size_r;
   assign status_cnt_tx_err = err_cnt_r;
   assign stall_irq         = irq_r;

endmodule
